// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, port owners and
// the streak counter width helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    RSP  = ST_RSP
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } owner_e;

  // Counter must hold STREAK_MAX and never be narrower than 3 bits.
  function automatic int streak_width(input int streak_max);
    int w;
    w = $clog2(streak_max + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner selection between fetch and data requesters.
// Data has priority unless the starvation guard reports a full streak.
module arb_priority_sel
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   streak_hit,
  output owner_e owner
);

  always_comb begin
    owner = NONE;
    if (streak_hit && i_req) begin
      owner = OWN_I;
    end else if (d_req) begin
      owner = OWN_D;
    end else if (i_req) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction
// in flight. Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no transaction; arbitrate, drive m_* from the winner
// REQ   | owner latched, m_req held until m_gnt
// RSP   | request accepted, waiting for m_rvalid
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  if (STREAK_MAX < 1) begin : g_bad_streak
    $error("STREAK_MAX must be at least 1");
  end

  state_e state_q;
  owner_e owner_q;
  owner_e sel_owner;
  owner_e cur_owner;
  logic   streak_hit;
  logic   mem_grant;
  logic   rsp_hit;

  arb_priority_sel u_sel (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak_hit (streak_hit),
    .owner      (sel_owner)
  );

  // In IDLE the fresh winner drives the port; afterwards the latched owner does.
  assign cur_owner = (state_q == IDLE) ? sel_owner : owner_q;

  assign m_req = reset &&
                 (((state_q == IDLE) && (sel_owner != NONE)) || (state_q == REQ));

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (reset) begin
      case (cur_owner)
        OWN_I: begin
          m_addr = i_addr;
          m_be   = {BE_W{1'b1}};
        end
        OWN_D: begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end
        default: ;
      endcase
    end
  end

  assign mem_grant = m_req && m_gnt;
  assign i_gnt     = mem_grant && (cur_owner == OWN_I);
  assign d_gnt     = mem_grant && (cur_owner == OWN_D);

  assign rsp_hit  = reset && (state_q == RSP) && m_rvalid;
  assign i_rvalid = rsp_hit && (owner_q == OWN_I);
  assign d_rvalid = rsp_hit && (owner_q == OWN_D);

  assign i_rdata = reset ? m_rdata : '0;
  assign d_rdata = reset ? m_rdata : '0;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_owner != NONE) begin
            owner_q <= sel_owner;
            state_q <= m_gnt ? RSP : REQ;
          end
        end
        REQ: begin
          if (m_gnt) state_q <= RSP;
        end
        RSP: begin
          if (m_rvalid) begin
            state_q <= IDLE;
            owner_q <= NONE;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= NONE;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_W = streak_width(STREAK_MAX);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_q;

  // Saturates so a data grant landing after a late i_req rise cannot skip past the hit value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (i_gnt) begin
      streak_q <= '0;
    end else if (d_gnt) begin
      if (!i_req) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_TOP) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end

  assign streak_hit = (streak_q == STREAK_TOP);
`else
  assign streak_hit = 1'b0;
`endif

`ifndef SYNTHESIS
  a_i_req_held : assert property (@(posedge clk) disable iff (!reset)
                                  (i_req && !i_gnt) |=> i_req);
  a_d_req_held : assert property (@(posedge clk) disable iff (!reset)
                                  (d_req && !d_gnt) |=> d_req);
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level model
// with a golden memory; honours ARB_STARVE_GUARD_EN like the design.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [BW-1:0] d_be;
  logic          m_req, m_we, m_gnt, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [BW-1:0] m_be;
  logic          busy;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int p_i, p_d, p_gnt, max_dly;

  bit          i_pend, d_pend;
  logic [31:0] ia, da, dwd;
  logic        dwe;
  logic [3:0]  dbe;

  // Transaction model: port free or held by one owner (1=fetch, 2=data).
  bit          mdl_free;
  int          mdl_own;
  bit          mdl_granted;
  int          streak;
  int          dly;
  logic [31:0] g_addr;
  bit          g_we;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];
  logic [31:0] dut_gaddr;

  bit       log_on;
  int       nlog;
  logic [9:0] glog;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : {a[15:0], 16'hC0DE};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], 16'hC0DE};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic int pick(input bit ir, input bit dr);
`ifdef ARB_STARVE_GUARD_EN
    if (ir && streak >= SMAX) return 1;
`endif
    if (dr) return 2;
    if (ir) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    mdl_free    = 1'b1;
    mdl_own     = 0;
    mdl_granted = 1'b0;
    streak      = 0;
    dly         = 0;
    i_pend      = 1'b0;
    d_pend      = 1'b0;
  endtask

  task automatic cycle();
    int  win;
    bit  emreq, egi, egd, erv;
    @(posedge clk);
    #1;
    if (!i_pend && ($urandom_range(0, 99) < p_i)) begin
      i_pend = 1'b1;
      ia     = 32'h100 + ($urandom_range(0, 15) << 2);
    end
    if (!d_pend && ($urandom_range(0, 99) < p_d)) begin
      d_pend = 1'b1;
      da     = 32'h100 + ($urandom_range(0, 15) << 2);
      dwe    = 1'($urandom_range(0, 1));
      dwd    = $urandom;
      dbe    = 4'($urandom_range(1, 15));
    end
    i_req   = i_pend;
    i_addr  = ia;
    d_req   = d_pend;
    d_addr  = da;
    d_we    = dwe;
    d_wdata = dwd;
    d_be    = dbe;
    m_gnt   = ($urandom_range(0, 99) < p_gnt);
    if (!mdl_free && mdl_granted && dly == 0) begin
      m_rvalid = 1'b1;
      m_rdata  = mem_rd(dut_gaddr);
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = $urandom;
      if (!mdl_free && mdl_granted) dly--;
    end

    @(negedge clk);
    win   = mdl_free ? pick(i_req, d_req) : mdl_own;
    emreq = mdl_free ? (win != 0) : !mdl_granted;
    egi   = emreq && m_gnt && (win == 1);
    egd   = emreq && m_gnt && (win == 2);
    erv   = !mdl_free && mdl_granted && m_rvalid;
    check("handshake", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy},
          {emreq, egi, egd, erv && win == 1, erv && win == 2, !mdl_free});
    if (emreq) begin
      if (win == 1) begin
        check("fetch_req", {m_we, m_be, m_addr}, {1'b0, 4'hF, ia});
      end else begin
        check("data_req", {m_we, m_be, m_addr}, {dwe, dbe, da});
        if (dwe) check("wdata", m_wdata, dwd);
      end
    end
    if (erv && win == 1) check("i_rdata", i_rdata, gold_rd(g_addr));
    if (erv && win == 2 && !g_we) check("d_rdata", d_rdata, gold_rd(g_addr));

    // Memory behaviour, driven purely by the DUT's memory pins.
    if (m_req && m_gnt) begin
      dut_gaddr = m_addr;
      if (m_we) mem[m_addr] = merge(mem_rd(m_addr), m_wdata, m_be);
    end

    if (egi || egd) begin
      mdl_free    = 1'b0;
      mdl_own     = win;
      mdl_granted = 1'b1;
      g_addr      = (win == 1) ? ia : da;
      g_we        = (win == 2) && dwe;
      dly         = $urandom_range(0, max_dly);
      if (win == 1) begin
        i_pend = 1'b0;
        streak = 0;
      end else begin
        d_pend = 1'b0;
        streak = i_req ? streak + 1 : 0;
        if (dwe) gold[da] = merge(gold_rd(da), dwd, dbe);
      end
      if (log_on && nlog < 10) begin
        glog[nlog] = (win == 1);
        nlog++;
      end
    end else if (mdl_free && win != 0) begin
      mdl_free    = 1'b0;
      mdl_own     = win;
      mdl_granted = 1'b0;
    end else if (erv) begin
      mdl_free    = 1'b1;
      mdl_own     = 0;
      mdl_granted = 1'b0;
    end
  endtask

  task automatic drain();
    p_i = 0;
    p_d = 0;
    for (int k = 0; k < 60 && !(mdl_free && !i_pend && !d_pend); k++) cycle();
    check("drain_done", {mdl_free, i_pend, d_pend}, 3'b100);
  endtask

  initial begin
    logic [9:0] exp_order;
    reset    = 1'b0;
    i_req    = 1'b1;
    i_addr   = 32'h100;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h2000;
    d_wdata  = 32'hDEAD_BEEF;
    d_be     = 4'b0011;
    m_gnt    = 1'b1;
    m_rvalid = 1'b0;
    m_rdata  = 32'h0000_0013;
    ia = 32'h100; da = 32'h104; dwd = 0; dwe = 0; dbe = 4'hF;
    log_on = 1'b0; nlog = 0; glog = '0; dut_gaddr = '0; g_addr = '0; g_we = 1'b0;
    model_reset();

    #2;
    check("reset_ctl", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, m_we, m_be}, '0);
    check("reset_addr", m_addr, '0);
    check("reset_wdata", m_wdata, '0);
    check("reset_rdata", {i_rdata, d_rdata}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    reset = 1'b1;

    p_i = 40; p_d = 40; p_gnt = 60; max_dly = 2;
    repeat (1500) cycle();
    drain();

    // Reset while a fetch is waiting for its response.
    p_i = 100; p_gnt = 100; max_dly = 0;
    for (int k = 0; k < 10 && !(mdl_granted && !mdl_free); k++) cycle();
    dly = 3;
    @(posedge clk);
    #1;
    i_req    = 1'b0;
    d_req    = 1'b0;
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    #1;
    check("rsp_busy", {busy, m_req}, 2'b10);
    #1;
    reset = 1'b0;
    #1;
    check("rst_rsp_ctl", {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, m_we, m_be}, '0);
    check("rst_rsp_addr", m_addr, '0);
    @(negedge clk);
    model_reset();
    reset = 1'b1;

    // Both requesters saturated from a clean streak.
    p_i = 100; p_d = 100; p_gnt = 100; max_dly = 0;
    log_on = 1'b1;
    nlog   = 0;
    for (int k = 0; k < 100 && nlog < 10; k++) cycle();
    log_on = 1'b0;
    check("grant_count", nlog, 10);
`ifdef ARB_STARVE_GUARD_EN
    exp_order = 10'b10000_10000;
`else
    exp_order = 10'b00000_00000;
`endif
    check("grant_order", glog, exp_order);

    p_i = 50; p_d = 50; p_gnt = 40; max_dly = 3;
    repeat (400) cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
